gavgpool_sched: RTL and testbench

Round-robin scheduler that shares one global-average-pooling datapath (accumulate, pipelined divide) between N_CH independent channel streams.
- Locks a channel for exactly POOL_SIZE accepted beats, then releases it.
- Records the granted channel index in a tag FIFO.
- Attaches that tag to each pooled result as it returns.
- Sits between the per-channel conv/activation outputs and the shared pooling datapath, ahead of the dense/classifier stage.

---
 rtl/gavgpool_sched.sv | 163 ++++++++++++++++
 tb/tb_gavgpool_sched.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gavgpool_sched.sv
`default_nettype none
// ============================================================================
// Module   : gavgpool_sched
// Purpose  : Round-robin sharing of one global-average-pooling datapath among
//            N_CH channel streams, with a tag FIFO labelling returning results.
//            Define GPSCHED_FIXED_PRIO_EN for fixed lowest-index-first priority.
// Revision : 1.0  initial release
// ============================================================================
module gavgpool_sched #(
    parameter int DATA_WIDTH = 12,
    parameter int N_CH       = 4,
    parameter int POOL_SIZE  = 250,
    parameter int ID_DEPTH   = 4,
    parameter int TAG_WIDTH  = $clog2(N_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [N_CH-1:0]              gpsched_ready_in,
    input  logic [N_CH-1:0]              gpsched_valid_in,
    input  logic [N_CH*DATA_WIDTH-1:0]   gpsched_data_in,
    input  logic                         pool_ready_in,
    output logic                         pool_valid_in,
    output logic [DATA_WIDTH-1:0]        pool_data_in,
    input  logic                         pool_valid_out,
    output logic                         pool_ready_out,
    input  logic [DATA_WIDTH-1:0]        pool_data_out,
    input  logic                         gpsched_ready_out,
    output logic                         gpsched_valid_out,
    output logic [DATA_WIDTH-1:0]        gpsched_data_out,
    output logic [TAG_WIDTH-1:0]         gpsched_tag_out,
    output logic                         gpsched_busy
);
    localparam int CNT_W  = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam int ADDR_W = (ID_DEPTH > 1) ? $clog2(ID_DEPTH) : 1;
    localparam logic [CNT_W-1:0]     C_LAST_BEAT = CNT_W'(POOL_SIZE - 1);
    localparam logic [TAG_WIDTH-1:0] C_LAST_CH   = TAG_WIDTH'(N_CH - 1);
    localparam logic [TAG_WIDTH:0]   C_N_CH      = (TAG_WIDTH+1)'(N_CH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t               r_state;
    logic [TAG_WIDTH-1:0] r_grant;
    logic [CNT_W-1:0]     r_cnt;
    logic [TAG_WIDTH-1:0] r_tag_mem [ID_DEPTH];
    logic [ADDR_W:0]      r_wr_ptr;
    logic [ADDR_W:0]      r_rd_ptr;

    logic [TAG_WIDTH-1:0] w_start;
    logic [TAG_WIDTH-1:0] w_sel;
    logic [TAG_WIDTH:0]   w_idx;
    logic                 w_found;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_beat;
    logic                 w_last;
    logic                 w_burst;

`ifdef GPSCHED_FIXED_PRIO_EN
    assign w_start = '0;
`else
    logic [TAG_WIDTH-1:0] r_rr_ptr;
    assign w_start = r_rr_ptr;
`endif

    // Descending scan so the smallest offset from w_start is the final winner.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            w_idx = {1'b0, w_start} + (TAG_WIDTH+1)'(i);
            if (w_idx >= C_N_CH) begin
                w_idx = w_idx - C_N_CH;
            end
            if (gpsched_valid_in[w_idx[TAG_WIDTH-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[TAG_WIDTH-1:0];
            end
        end
    end

    assign w_burst = (r_state == S_BURST);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr == {~r_rd_ptr[ADDR_W], r_rd_ptr[ADDR_W-1:0]});
    assign w_push  = (r_state == S_IDLE) && w_found && !w_full;
    assign w_beat  = pool_valid_in && pool_ready_in;
    assign w_last  = (r_cnt == C_LAST_BEAT);
    assign w_pop   = gpsched_valid_out && gpsched_ready_out;

    assign pool_valid_in    = w_burst && gpsched_valid_in[r_grant];
    assign pool_data_in     = gpsched_data_in[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
    assign gpsched_ready_in = ({{(N_CH-1){1'b0}}, 1'b1} << r_grant)
                              & {N_CH{w_burst && pool_ready_in}};

    assign gpsched_valid_out = pool_valid_out && !w_empty;
    assign pool_ready_out    = gpsched_ready_out;
    assign gpsched_data_out  = pool_data_out;
    assign gpsched_tag_out   = r_tag_mem[r_rd_ptr[ADDR_W-1:0]];
    assign gpsched_busy      = w_burst || !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_cnt    <= '0;
`ifndef GPSCHED_FIXED_PRIO_EN
            r_rr_ptr <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_push) begin
                        r_grant <= w_sel;
                        r_cnt   <= '0;
                        r_state <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_beat) begin
                        if (w_last) begin
                            r_cnt    <= '0;
                            r_state  <= S_IDLE;
`ifndef GPSCHED_FIXED_PRIO_EN
                            r_rr_ptr <= (r_grant == C_LAST_CH) ? '0 : r_grant + 1'b1;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Grant order equals result order, so a plain FIFO pairs tags to results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr[ADDR_W-1:0]] <= w_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gavgpool_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_gavgpool_sched
// Purpose  : Directed bench for gavgpool_sched with a transaction-level model,
//            an ideal averaging datapath and per-cycle output comparison.
// Revision : 1.0  initial release
// ============================================================================
module tb_gavgpool_sched;
    localparam int C_DW   = 12;
    localparam int C_N    = 4;
    localparam int C_POOL = 4;
    localparam int C_DEP  = 2;
    localparam int C_LAT  = 2;
`ifdef GPSCHED_FIXED_PRIO_EN
    localparam bit C_FIXED = 1'b1;
`else
    localparam bit C_FIXED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [C_N-1:0]    valid_in = '0;
    logic [C_N*C_DW-1:0] data_in = '0;
    logic              pool_ready_in = 1'b1;
    logic              pool_valid_out = 1'b0;
    logic [C_DW-1:0]   pool_data_out = '0;
    logic              gpsched_ready_out = 1'b1;
    logic [C_N-1:0]    gpsched_ready_in;
    logic              pool_valid_in;
    logic [C_DW-1:0]   pool_data_in;
    logic              pool_ready_out;
    logic              gpsched_valid_out;
    logic [C_DW-1:0]   gpsched_data_out;
    logic [1:0]        gpsched_tag_out;
    logic              gpsched_busy;

    gavgpool_sched #(
        .DATA_WIDTH (C_DW),
        .N_CH       (C_N),
        .POOL_SIZE  (C_POOL),
        .ID_DEPTH   (C_DEP)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .gpsched_ready_in  (gpsched_ready_in),
        .gpsched_valid_in  (valid_in),
        .gpsched_data_in   (data_in),
        .pool_ready_in     (pool_ready_in),
        .pool_valid_in     (pool_valid_in),
        .pool_data_in      (pool_data_in),
        .pool_valid_out    (pool_valid_out),
        .pool_ready_out    (pool_ready_out),
        .pool_data_out     (pool_data_out),
        .gpsched_ready_out (gpsched_ready_out),
        .gpsched_valid_out (gpsched_valid_out),
        .gpsched_data_out  (gpsched_data_out),
        .gpsched_tag_out   (gpsched_tag_out),
        .gpsched_busy      (gpsched_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit run_cmp  = 1'b0;
    int cyc      = 0;

    // Scheduler model: burst flag, granted channel, beats left, pointer, tags in flight.
    bit m_burst = 1'b0;
    int m_g = 0, m_left = 0, m_ptr = 0;
    int m_tags[$];
    int m_grants[$];

    // Ideal datapath: averages each window and returns it C_LAT cycles later.
    int dp_res[$];
    int dp_at[$];
    int dp_sum = 0, dp_n = 0;

    // Observations of the DUT, cleared per scenario.
    int beat_ch[$], beat_data[$], beat_cyc[$], out_tag[$], out_data[$];
    logic [C_N-1:0] rdy_seen = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int onehot_idx(input logic [C_N-1:0] v);
        int r = -1;
        for (int k = 0; k < C_N; k++) if (v[k]) r = k;
        return r;
    endfunction

    initial begin
        logic [C_N-1:0] e_rdy;
        bit e_pv, e_vo, e_busy, full;
        forever begin
            @(negedge clk);
            if (dp_res.size() > 0 && dp_at[0] <= cyc) begin
                pool_valid_out = 1'b1;
                pool_data_out  = C_DW'(dp_res[0]);
            end else begin
                pool_valid_out = 1'b0;
                pool_data_out  = '0;
            end
            #3;
            if (run_cmp) begin
                e_rdy  = (m_burst && pool_ready_in) ? C_N'(1 << m_g) : '0;
                e_pv   = m_burst && valid_in[m_g];
                e_vo   = pool_valid_out && (m_tags.size() > 0);
                e_busy = m_burst || (m_tags.size() > 0);
                chk("ready_in", gpsched_ready_in, e_rdy);
                chk("pool_valid_in", pool_valid_in, e_pv);
                if (e_pv) chk("pool_data_in", pool_data_in, data_in[m_g*C_DW +: C_DW]);
                chk("valid_out", gpsched_valid_out, e_vo);
                if (e_vo) begin
                    chk("tag_out", gpsched_tag_out, m_tags[0]);
                    chk("data_out", gpsched_data_out, pool_data_out);
                end
                chk("pool_ready_out", pool_ready_out, gpsched_ready_out);
                chk("busy", gpsched_busy, e_busy);

                if (!rst) begin
                    rdy_seen |= gpsched_ready_in;
                    if (pool_valid_in && pool_ready_in) begin
                        beat_ch.push_back(onehot_idx(gpsched_ready_in));
                        beat_data.push_back(int'(pool_data_in));
                        beat_cyc.push_back(cyc);
                    end
                    if (gpsched_valid_out && gpsched_ready_out) begin
                        out_tag.push_back(int'(gpsched_tag_out));
                        out_data.push_back(int'(gpsched_data_out));
                    end
                end

                if (rst) begin
                    m_burst = 1'b0; m_g = 0; m_left = 0; m_ptr = 0;
                    m_tags.delete();
                end else begin
                    full = (m_tags.size() >= C_DEP);
                    if (e_vo && gpsched_ready_out) void'(m_tags.pop_front());
                    if (!m_burst) begin
                        if (!full && valid_in != '0) begin
                            for (int k = C_N - 1; k >= 0; k--)
                                if (valid_in[(m_ptr + k) % C_N]) m_g = (m_ptr + k) % C_N;
                            m_tags.push_back(m_g);
                            m_grants.push_back(m_g);
                            m_burst = 1'b1;
                            m_left  = C_POOL;
                        end
                    end else if (e_pv && pool_ready_in) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_burst = 1'b0;
                            m_ptr   = C_FIXED ? 0 : (m_g + 1) % C_N;
                        end
                    end
                end
            end
            if (rst) begin
                dp_res.delete(); dp_at.delete(); dp_sum = 0; dp_n = 0;
            end else begin
                if (pool_valid_out && pool_ready_out) begin
                    void'(dp_res.pop_front());
                    void'(dp_at.pop_front());
                end
                if (pool_valid_in && pool_ready_in) begin
                    dp_sum += int'(pool_data_in);
                    dp_n++;
                    if (dp_n == C_POOL) begin
                        dp_res.push_back(dp_sum / C_POOL);
                        dp_at.push_back(cyc + C_LAT);
                        dp_sum = 0;
                        dp_n   = 0;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_data(input int ch, input int val);
        data_in[ch*C_DW +: C_DW] = C_DW'(val);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid_in = '0; data_in = '0;
        pool_ready_in = 1'b1; gpsched_ready_out = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        beat_ch.delete(); beat_data.delete(); beat_cyc.delete();
        out_tag.delete(); out_data.delete(); m_grants.delete();
        rdy_seen = '0;
    endtask

    initial begin
        int exp3;
        exp3 = C_FIXED ? 0 : 3;
        wait_cyc(2);
        run_cmp = 1'b1;
        #4;
        chk("rst_ready_in", gpsched_ready_in, 0);
        chk("rst_pool_valid_in", pool_valid_in, 0);
        chk("rst_valid_out", gpsched_valid_out, 0);
        chk("rst_busy", gpsched_busy, 0);

        // Scenario 1: lone ch2 window 1,2,3,4 -> average 2 tagged 2.
        do_reset();
        valid_in = 4'b0100; set_data(2, 1);
        wait_cyc(2); set_data(2, 2);
        wait_cyc(1); set_data(2, 3);
        wait_cyc(1); set_data(2, 4);
        wait_cyc(1); valid_in = '0;
        wait_cyc(8);
        chk("t1_nbeats", beat_data.size(), 4);
        for (int k = 0; k < 4 && k < beat_data.size(); k++) begin
            chk("t1_beat_data", beat_data[k], k + 1);
            chk("t1_beat_ch", beat_ch[k], 2);
        end
        if (beat_cyc.size() == 4) chk("t1_consecutive", beat_cyc[3] - beat_cyc[0], 3);
        chk("t1_rdy_seen", rdy_seen, 4'b0100);
        chk("t1_nout", out_tag.size(), 1);
        if (out_tag.size() > 0) begin
            chk("t1_tag", out_tag[0], 2);
            chk("t1_avg", out_data[0], 2);
        end

        // Scenario 2: all channels valid -> 0,1,2,3,0 with one idle cycle between bursts.
        do_reset();
        valid_in = 4'hF;
        for (int c = 0; c < C_N; c++) set_data(c, 100 + c);
        wait_cyc(25);
        valid_in = '0;
        wait_cyc(10);
        chk("t2_nbeats_min", beat_ch.size() >= 20, 1);
        for (int k = 0; k < 20 && k < beat_ch.size(); k++) chk("t2_beat_ch", beat_ch[k], (k / 4) % 4);
        if (beat_cyc.size() > 4) chk("t2_idle_gap", beat_cyc[4] - beat_cyc[3], 2);
        for (int k = 0; k < 5 && k < m_grants.size(); k++) chk("t2_model_grant", m_grants[k], k % 4);
        for (int k = 0; k < 4 && k < out_tag.size(); k++) begin
            chk("t2_tag", out_tag[k], k);
            chk("t2_avg", out_data[k], 100 + k);
        end

        // Scenario 3: downstream stalled -> FIFO fills after ch0, ch1; then tag 0 pops and ch2 follows.
        do_reset();
        gpsched_ready_out = 1'b0;
        valid_in = 4'hF;
        for (int c = 0; c < C_N; c++) set_data(c, 100 + c);
        wait_cyc(25);
        chk("t3_grants_full", m_grants.size(), 2);
        chk("t3_beats_full", beat_ch.size(), 8);
        chk("t3_no_out", out_tag.size(), 0);
        gpsched_ready_out = 1'b1;
        wait_cyc(15);
        if (out_tag.size() > 1) begin
            chk("t3_first_tag", out_tag[0], 0);
            chk("t3_second_tag", out_tag[1], 1);
        end else chk("t3_out_count", out_tag.size(), 2);
        if (beat_ch.size() > 8) chk("t3_third_ch", beat_ch[8], 2);
        else chk("t3_third_beats", beat_ch.size(), 9);
        if (m_grants.size() > 2) chk("t3_model_third", m_grants[2], 2);

        // Scenario 4: ch1 burst with pool_ready_in low for 3 cycles after beat 2.
        do_reset();
        valid_in = 4'b0010; set_data(1, 10);
        wait_cyc(2); set_data(1, 20);
        wait_cyc(1); set_data(1, 30); pool_ready_in = 1'b0;
        wait_cyc(3); pool_ready_in = 1'b1;
        wait_cyc(1); set_data(1, 40);
        wait_cyc(1); valid_in = '0;
        wait_cyc(8);
        chk("t4_nbeats", beat_data.size(), 4);
        for (int k = 0; k < 4 && k < beat_data.size(); k++) chk("t4_beat_data", beat_data[k], 10 * (k + 1));
        if (beat_cyc.size() > 2) chk("t4_stall_gap", beat_cyc[2] - beat_cyc[1], 4);
        chk("t4_rdy_seen", rdy_seen, 4'b0010);
        if (out_data.size() > 0) begin
            chk("t4_avg", out_data[0], 25);
            chk("t4_tag", out_tag[0], 1);
        end else chk("t4_nout", out_data.size(), 1);

        // Scenario 5: reset after 2 beats of a ch3 burst, then a clean ch0 window.
        do_reset();
        valid_in = 4'b1000; set_data(3, 50);
        wait_cyc(3);
        chk("t5_beats_before_rst", beat_ch.size(), 2);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0; valid_in = '0;
        #4;
        chk("t5_ready_in", gpsched_ready_in, 0);
        chk("t5_pool_valid_in", pool_valid_in, 0);
        chk("t5_valid_out", gpsched_valid_out, 0);
        chk("t5_busy", gpsched_busy, 0);
        @(negedge clk);
        valid_in = 4'hF;
        for (int c = 0; c < C_N; c++) set_data(c, 200 + c);
        wait_cyc(5);
        valid_in = '0;
        wait_cyc(8);
        chk("t5_nbeats", beat_ch.size(), 6);
        for (int k = 2; k < 6 && k < beat_ch.size(); k++) chk("t5_beat_ch", beat_ch[k], 0);
        chk("t5_nout", out_tag.size(), 1);
        if (out_tag.size() > 0) begin
            chk("t5_tag", out_tag[0], 0);
            chk("t5_avg", out_data[0], 200);
        end

        // Scenario 6: ch0 and ch3 valid -> alternate under round-robin, ch0 only under fixed priority.
        do_reset();
        valid_in = 4'b1001; set_data(0, 5); set_data(3, 9);
        wait_cyc(20);
        valid_in = '0;
        wait_cyc(10);
        chk("t6_ngrants", m_grants.size(), 4);
        if (m_grants.size() > 2) begin
            chk("t6_grant0", m_grants[0], 0);
            chk("t6_grant1", m_grants[1], exp3);
            chk("t6_grant2", m_grants[2], 0);
        end
        if (beat_ch.size() > 4) chk("t6_second_burst_ch", beat_ch[4], exp3);
        if (out_tag.size() > 1) chk("t6_second_tag", out_tag[1], exp3);
        else chk("t6_nout", out_tag.size(), 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
